// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes and the mul/div sequencer state type.
package alu_pkg;

    // ALUControl encodings, shared with the single-cycle ALU control.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1111;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } muldiv_state_e;

    // True for the codes the multi-cycle unit acts on.
    function automatic logic is_muldiv_op(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
module muldiv_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             op_is_div_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic [WIDTH-1:0] next_hi_o,
    output logic [WIDTH-1:0] next_lo_o
);

    // hi_q: product upper half / remainder; lo_q: multiplier / quotient.
    // b_q: multiplicand / divisor.
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH:0]   div_diff;

    // Next value of {hi, lo} after one iteration of the selected operation.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
        // Remainder after the left shift, kept one bit wider for the trial subtract.
        div_rem  = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, b_q};
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (op_is_div_i) begin
            if (!div_diff[WIDTH]) begin
                hi_d = div_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_rem[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // {carry, hi} shifted right into lo.
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign next_hi_o = hi_d;
    assign next_lo_o = lo_d;

    // Operand load on accept, one iteration per step cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load_i) begin
            hi_q <= '0;
            lo_q <= op_is_div_i ? operand_a_i : operand_b_i;
            b_q  <= op_is_div_i ? operand_b_i : operand_a_i;
        end else if (step_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle mul/div sequencer: FSM, iteration counter, stall and result handshake.
module alu_muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] res_lo_q, res_hi_q;

    logic             is_div, can_accept, accept, div_zero;
    logic             dp_load, dp_op_is_div;
    logic [WIDTH-1:0] dp_hi, dp_lo;

    // Accept decode and datapath control.
    always_comb begin
        is_div       = (alu_control == ALU_DIV);
        can_accept   = (state_q == StIdle) || (state_q == StDone);
        accept       = start && can_accept && is_muldiv_op(alu_control);
        div_zero     = is_div && (operand_b == '0);
        // Divide by zero never iterates, so the datapath is left alone.
        dp_load      = accept && !div_zero;
        dp_op_is_div = accept ? is_div : (state_q == StDiv);
    end

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load_i      (dp_load),
        .step_i      (busy_q),
        .op_is_div_i (dp_op_is_div),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .next_hi_o   (dp_hi),
        .next_lo_o   (dp_lo)
    );

    // Sequencer FSM with registered busy/done/result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (div_zero) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            dbz_q    <= 1'b1;
                            res_lo_q <= '1;
                            res_hi_q <= operand_a;
                        end else begin
                            state_q <= is_div ? StDiv : StMul;
                            cnt_q   <= CNT_W'(WIDTH);
                            busy_q  <= 1'b1;
                            dbz_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StMul, StDiv: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last iteration: capture the datapath's final step directly.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= StDone;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        res_lo_q <= dp_lo;
                        res_hi_q <= dp_hi;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    // Holds the issuing instruction from its first EX cycle.
    assign stall       = busy_q | accept;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer: directed cases plus random mul/div traffic.
module tb_alu_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0010;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alu_control;
    logic [W-1:0] operand_a, operand_b;
    logic         busy, stall, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    alu_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           at;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        e.dbz = 1'b0;
        e.at  = W + 1;
        if (op == OP_MUL) begin
            p    = {32'b0, a} * {32'b0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 0) begin
            e.hi  = a;
            e.lo  = '1;
            e.dbz = 1'b1;
            e.at  = 1;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.at));
                    chk("result_hi", 64'(result_hi), 64'(e.hi));
                    chk("result_lo", 64'(result_lo), 64'(e.lo));
                    chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                end
            end
        end
    end

    // Drive an accepted request at the current negedge; returns its latency.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        exp_t e;
        start       = 1'b1;
        alu_control = op;
        operand_a   = a;
        operand_b   = b;
        e           = model(op, a, b);
        lat         = e.at;
        e.at        = cyc + e.at;
        sb.push_back(e);
        #1;
        chk("stall_on_accept", 64'(stall), 64'd1);
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        issue(op, a, b, lat);
        release_start();
        wait_idle();
    endtask

    initial begin
        int           lat;
        logic [3:0]   op;
        logic [W-1:0] a, b;

        reset       = 1'b1;
        start       = 1'b0;
        alu_control = 4'b0;
        operand_a   = '0;
        operand_b   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_lo", 64'(result_lo), 64'd0);
        chk("rst_hi", 64'(result_hi), 64'd0);
        @(negedge clk);

        // 7 x 6 with cycle-by-cycle stall tracking.
        issue(OP_MUL, 32'd7, 32'd6, lat);
        release_start();
        for (int i = 1; i < lat; i++) begin
            #1;
            chk("stall_while_busy", 64'(stall), 64'd1);
            chk("busy_while_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        #1;
        chk("stall_in_done", 64'(stall), 64'd0);
        chk("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("result_held", 64'(result_lo), 64'd42);
        wait_idle();

        run(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(OP_DIV, 32'd100, 32'd7);
        run(OP_DIV, 32'd5, 32'd0);

        // Non-mul/div code is ignored.
        start       = 1'b1;
        alu_control = OP_ADD;
        #1;
        chk("add_stall", 64'(stall), 64'd0);
        release_start();
        #1;
        chk("add_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        // start mid-multiply is ignored.
        issue(OP_MUL, 32'd3, 32'd4, lat);
        release_start();
        repeat (9) @(negedge clk);
        start       = 1'b1;
        alu_control = OP_DIV;
        operand_a   = 32'd99;
        operand_b   = 32'd0;
        release_start();
        wait_idle();

        // Reset mid-divide aborts without a done pulse.
        issue(OP_DIV, 32'd1000, 32'd10, lat);
        release_start();
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_lo", 64'(result_lo), 64'd0);
        chk("abort_hi", 64'(result_hi), 64'd0);
        repeat (40) @(negedge clk);
        run(OP_MUL, 32'd9, 32'd9);

        // Back-to-back: new divide accepted in the DONE cycle.
        issue(OP_MUL, 32'd2, 32'd3, lat);
        release_start();
        repeat (lat - 1) @(negedge clk);
        issue(OP_DIV, 32'd50, 32'd5, lat);
        release_start();
        #1;
        chk("b2b_stall", 64'(stall), 64'd1);
        wait_idle();

        // Random traffic, sometimes chained back-to-back.
        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(1) ? OP_MUL : OP_DIV;
            a  = $urandom;
            case ($urandom_range(3))
                0:       b = '0;
                1:       b = W'($urandom_range(15));
                default: b = $urandom;
            endcase
            issue(op, a, b, lat);
            release_start();
            if (lat > 1 && $urandom_range(1) == 1) repeat (lat - 1) @(negedge clk);
            else wait_idle();
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
